// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the ID-stage hazard scoreboard: RV32 opcodes, the MUL/DIV funct7
// value, and the producer class recorded for each in-flight register write.
package hazard_scoreboard_pkg;

    localparam logic [6:0] OP_LUI        = 7'b0110111;
    localparam logic [6:0] OP_AUIPC      = 7'b0010111;
    localparam logic [6:0] OP_JAL        = 7'b1101111;
    localparam logic [6:0] OP_JALR       = 7'b1100111;
    localparam logic [6:0] OP_BRANCH     = 7'b1100011;
    localparam logic [6:0] OP_LOAD       = 7'b0000011;
    localparam logic [6:0] OP_STORE      = 7'b0100011;
    localparam logic [6:0] OP_ARITH_IMM  = 7'b0010011;
    localparam logic [6:0] OP_ARITH      = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM     = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2
    } src_cls_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: instruction/issue/pipeline-control inputs toward the scoreboard
// and the stall outputs back to the ID stage.
interface hazard_scoreboard_if #(
    parameter int STAT_W = 32
);
    logic [31:0]       IF_ID_inst;
    logic              is_ecall;
    logic              id_issue;
    logic [4:0]        id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              pipe_freeze;
    logic              ex_flush;
    logic              is_hazard;
    logic              hazard_rs1;
    logic              hazard_rs2;
    logic              hazard_ecall;
    logic [STAT_W-1:0] stall_cnt;

    modport master (
        output IF_ID_inst, is_ecall, id_issue, id_rd, id_reg_write, id_mem_read,
               pipe_freeze, ex_flush,
        input  is_hazard, hazard_rs1, hazard_rs2, hazard_ecall, stall_cnt
    );

    modport slave (
        input  IF_ID_inst, is_ecall, id_issue, id_rd, id_reg_write, id_mem_read,
               pipe_freeze, ex_flush,
        output is_hazard, hazard_rs1, hazard_rs2, hazard_ecall, stall_cnt
    );

endinterface

// File: rtl/hazard_src_decode.sv
// Source-operand decode for the ID instruction: which of rs1/rs2 are read, and whether the
// instruction is a multiply-class producer.
module hazard_src_decode
    import hazard_scoreboard_pkg::*;
#(
    parameter int MUL_EN = 0
) (
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic        is_mul
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       rd_rs1;
    logic       rd_rs2;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct7      = inst[31:25];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^inst[14:7];

    always_comb begin
        rd_rs1 = 1'b0;
        rd_rs2 = 1'b0;
        case (opcode)
            OP_ARITH, OP_STORE, OP_BRANCH: begin
                rd_rs1 = 1'b1;
                rd_rs2 = 1'b1;
            end
            OP_ARITH_IMM, OP_LOAD, OP_JALR: rd_rs1 = 1'b1;
            default: ;
        endcase
    end

    // x0 reads are constant and can never wait on a producer.
    assign use_rs1 = rd_rs1 && (rs1 != 5'd0);
    assign use_rs2 = rd_rs2 && (rs2 != 5'd0);
    assign is_mul  = (MUL_EN != 0) && (opcode == OP_ARITH) && (funct7 == FUNCT7_MULDIV);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that stalls ID until each source operand is readable,
// either through forwarding (class-dependent threshold) or from the register file.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int FWD_EN     = 1,
    parameter int WB_STALL   = 2,
    parameter int LOAD_STALL = 1,
    parameter int MUL_EN     = 0,
    parameter int MUL_STALL  = 2,
    parameter int STAT_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  hz
);

    localparam int              CNT_W    = (WB_STALL < 1) ? 1 : $clog2(WB_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_STALL);

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       is_mul;

    logic [CNT_W-1:0]  cnt_q [32];
    logic [CNT_W-1:0]  cnt_d [32];
    src_cls_e          cls_q [32];
    src_cls_e          cls_d [32];
    logic              ex_v_q, ex_v_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic haz_rs1_raw;
    logic haz_rs2_raw;
    logic haz_ecall_raw;
    logic haz_any_raw;

    hazard_src_decode #(
        .MUL_EN (MUL_EN)
    ) u_src_decode (
        .inst    (hz.IF_ID_inst),
        .rs1     (rs1),
        .rs2     (rs2),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .is_mul  (is_mul)
    );

    function automatic int settle_of(input src_cls_e c);
        case (c)
            CLS_LOAD: return LOAD_STALL;
            CLS_MUL:  return MUL_STALL;
            default:  return 0;
        endcase
    endfunction

    // With forwarding, a producer becomes usable once its count drops to the class threshold.
    function automatic logic not_ready(input logic [CNT_W-1:0] c, input src_cls_e k);
        if (FWD_EN == 0)
            return c != '0;
        return int'(c) > (WB_STALL - settle_of(k));
    endfunction

    assign haz_rs1_raw   = use_rs1 && not_ready(cnt_q[rs1], cls_q[rs1]);
    assign haz_rs2_raw   = use_rs2 && not_ready(cnt_q[rs2], cls_q[rs2]);
    assign haz_ecall_raw = hz.is_ecall && (cnt_q[17] != '0);
    assign haz_any_raw   = haz_rs1_raw || haz_rs2_raw || haz_ecall_raw;

    assign hz.hazard_rs1   = haz_rs1_raw && !reset;
    assign hz.hazard_rs2   = haz_rs2_raw && !reset;
    assign hz.hazard_ecall = haz_ecall_raw && !reset;
    assign hz.is_hazard    = haz_any_raw && !reset;
    assign hz.stall_cnt    = stall_cnt_q;

    always_comb begin
        cnt_d       = cnt_q;
        cls_d       = cls_q;
        ex_v_d      = ex_v_q;
        ex_rd_d     = ex_rd_q;
        stall_cnt_d = stall_cnt_q;
        if (!hz.pipe_freeze) begin
            if (haz_any_raw)
                stall_cnt_d = stall_cnt_q + STAT_W'(1);
            for (int i = 1; i < 32; i++) begin
                if (cnt_q[i] != '0)
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
            // A squashed EX instruction never writes back, and the ID instruction may not enter EX.
            if (hz.ex_flush && ex_v_q) begin
                cnt_d[ex_rd_q] = '0;
                ex_v_d         = 1'b0;
            end else if (hz.id_issue) begin
                if (hz.id_reg_write && (hz.id_rd != 5'd0)) begin
                    cnt_d[hz.id_rd] = CNT_FULL;
                    cls_d[hz.id_rd] = hz.id_mem_read ? CLS_LOAD :
                                      is_mul         ? CLS_MUL  : CLS_ALU;
                    ex_v_d          = 1'b1;
                    ex_rd_d         = hz.id_rd;
                end else begin
                    ex_v_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
                cls_q[i] <= CLS_ALU;
            end
            ex_v_q      <= 1'b0;
            ex_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cls_q       <= cls_d;
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
